subcore_dispatcher: RTL
=======================

// Module: subcore_dispatcher
// PURPOSE
//   Sits between the main core and the SUBCORE_NUM sub cores. Accepts fork requests (start PC) from
//   main, assigns each to the lowest-index idle sub core and pulses that core's exec_requested with
//   its PC. Tracks per-core busy state from subcore_ended pulses and services join requests: signals
//   main once every sub core in a given mask has finished.
// PARAMETERS
//   SUBCORE_NUM  8   number of sub cores managed (1..16)
//   PC_W         32  width of a program counter
// PORTS
//   clk             in   1                  system clock, all logic on rising edge
//   rst             in   1                  asynchronous reset, active-high
//   fork_valid      in   1                  main requests a sub core start
//   fork_pc         in   PC_W               start PC for the fork
//   fork_ready      out  1                  at least one sub core idle; fork accepted when valid&ready
//   fork_id         out  $clog2(SUBCORE_NUM) index of the core chosen by the last accepted fork
//   exec_requested  out  SUBCORE_NUM        one-cycle start pulse per sub core
//   requested_pc    out  SUBCORE_NUM x PC_W start PC per sub core, held until next start of that core
//   subcore_ended   in   SUBCORE_NUM        one-cycle completion pulse per sub core
//   join_valid      in   1                  main requests a wait on join_mask
//   join_mask       in   SUBCORE_NUM        cores to wait for
//   join_done       out  1                  one-cycle pulse: all masked cores idle
//   busy            out  SUBCORE_NUM        registered busy bit per core
//   busy_count      out  $clog2(SUBCORE_NUM+1) popcount of busy
//   err_spurious    out  1                  sticky: subcore_ended seen on an idle core
// BEHAVIOUR
//   Reset (async, any cycle, incl. mid-join): busy=0, exec_requested=0, requested_pc=0, fork_id=0,
//     join_done=0, err_spurious=0, join FSM->J_IDLE, stored join mask=0. fork_ready=1 after reset.
//   fork_ready = ~&busy (combinational from registered busy; independent of fork_valid).
//   Fork accepted in cycle T (fork_valid&fork_ready): k = lowest index with busy[k]==0 at T.
//     At T+1: exec_requested[k]=1 (that cycle only), requested_pc[k]=fork_pc(T), busy[k]=1,
//     fork_id=k. Back-to-back forks every cycle allowed; each picks from the updated busy.
//   Fork with fork_ready=0: ignored, no state change; main must hold fork_valid.
//   subcore_ended[i] in cycle T with busy[i]=1: busy[i]=0 at T+1. Core i is not selectable by a
//     fork in cycle T (selection uses registered busy); it is selectable from T+1.
//   subcore_ended[i] with busy[i]=0: ignored, err_spurious set to 1 until reset.
//   Multiple subcore_ended bits in one cycle: all handled in that cycle.
//   Fork assigning core k and subcore_ended on other cores in same cycle: both take effect.
//   Join FSM:
//     J_IDLE: join_valid -> latch join_mask, go J_WAIT. join_done=0.
//     J_WAIT: if (busy & mask)==0 -> J_DONE; else stay. join_valid ignored here.
//     J_DONE: join_done=1 for exactly this cycle, -> J_IDLE. join_valid ignored here; a new join
//       is accepted only from J_IDLE.
//     Min latency: join_valid at T with masked cores idle -> join_done at T+2.
//     Forks during J_WAIT are accepted; a fork to a masked core extends the wait.
//     join_mask==0: completes with min latency.
//   busy_count = popcount(busy), updated with busy, never exceeds SUBCORE_NUM.
//   No combinational path from fork_valid/fork_pc/subcore_ended/join_* to any output.
// TESTING
//   Reset, fork_pc=0x100 valid 1 cycle -> next cycle exec_requested=8'h01, requested_pc[0]=0x100,
//     busy=8'h01, fork_id=0, busy_count=1.
//   8 back-to-back forks PC 0x10..0x17 -> cores 0..7 pulsed in order, busy=8'hFF, fork_ready=0;
//     9th fork held until subcore_ended[3] -> fork goes to core 3 one cycle after busy[3] clears.
//   Cores 0,1,2 busy; join_mask=8'h05; end core 0, then 5 cycles later core 2 -> join_done
//     pulses once, 2 cycles after subcore_ended[2]; ending core 1 not required.
//   join_mask=8'h00 at T -> join_done at T+2; second join_valid during J_WAIT ignored.
//   subcore_ended[5] with core 5 idle -> err_spurious=1 and stays 1; busy unchanged.
//   Assert rst during J_WAIT with busy=8'hF0 -> all outputs zero immediately, fork_ready=1.

Source files
------------

// File: rtl/subcore_dispatcher.sv
// Dispatches fork requests from the main core to the lowest-index idle sub core,
// tracks per-core busy state and signals main when a masked set of cores has finished.
module subcore_dispatcher #(
  parameter int unsigned SUBCORE_NUM = 8,
  parameter int unsigned PC_W        = 32,
  localparam int unsigned ID_W  = (SUBCORE_NUM > 1) ? $clog2(SUBCORE_NUM) : 1,
  localparam int unsigned CNT_W = $clog2(SUBCORE_NUM + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                fork_valid,
  input  logic [PC_W-1:0]                     fork_pc,
  output logic                                fork_ready,
  output logic [ID_W-1:0]                     fork_id,
  output logic [SUBCORE_NUM-1:0]              exec_requested,
  output logic [SUBCORE_NUM-1:0][PC_W-1:0]    requested_pc,
  input  logic [SUBCORE_NUM-1:0]              subcore_ended,
  input  logic                                join_valid,
  input  logic [SUBCORE_NUM-1:0]              join_mask,
  output logic                                join_done,
  output logic [SUBCORE_NUM-1:0]              busy,
  output logic [CNT_W-1:0]                    busy_count,
  output logic                                err_spurious
);

  typedef enum logic [1:0] {
    J_IDLE,
    J_WAIT,
    J_DONE
  } join_state_t;

  join_state_t            join_state;
  logic [SUBCORE_NUM-1:0] join_mask_q;

  logic                   fork_fire;
  logic [ID_W-1:0]        pick_id;
  logic [SUBCORE_NUM-1:0] pick_oh;
  logic [SUBCORE_NUM-1:0] busy_nxt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   spurious;

  assign fork_ready = ~&busy;
  assign fork_fire  = fork_valid & fork_ready;
  assign spurious   = |(subcore_ended & ~busy);

  // Lowest-index idle core; scanning downward lets the lowest index win.
  always_comb begin
    pick_id = '0;
    for (int i = SUBCORE_NUM - 1; i >= 0; i--) begin
      if (!busy[i]) pick_id = ID_W'(i);
    end
    pick_oh = '0;
    for (int i = 0; i < SUBCORE_NUM; i++) begin
      pick_oh[i] = fork_fire && (pick_id == ID_W'(i));
    end
  end

  // Ends clear busy; a fork can only target an idle core, so the set bit never collides.
  always_comb begin
    busy_nxt = (busy & ~subcore_ended) | pick_oh;
    cnt_nxt  = '0;
    for (int i = 0; i < SUBCORE_NUM; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= '0;
      busy_count     <= '0;
      exec_requested <= '0;
      requested_pc   <= '0;
      fork_id        <= '0;
      err_spurious   <= 1'b0;
    end else begin
      busy           <= busy_nxt;
      busy_count     <= cnt_nxt;
      exec_requested <= pick_oh;
      err_spurious   <= err_spurious | spurious;
      if (fork_fire) fork_id <= pick_id;
      for (int i = 0; i < SUBCORE_NUM; i++) begin
        if (pick_oh[i]) requested_pc[i] <= fork_pc;
      end
    end
  end

  // Join FSM; completion is judged on registered busy, so the earliest done is two cycles out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      join_state  <= J_IDLE;
      join_mask_q <= '0;
      join_done   <= 1'b0;
    end else begin
      case (join_state)
        J_IDLE: begin
          join_done <= 1'b0;
          if (join_valid) begin
            join_mask_q <= join_mask;
            join_state  <= J_WAIT;
          end
        end
        J_WAIT: begin
          if ((busy & join_mask_q) == '0) begin
            join_state <= J_DONE;
            join_done  <= 1'b1;
          end
        end
        J_DONE: begin
          join_done  <= 1'b0;
          join_state <= J_IDLE;
        end
        default: begin
          join_done  <= 1'b0;
          join_state <= J_IDLE;
        end
      endcase
    end
  end

endmodule
